// File: rtl/mac_unit_bitlet_stream.sv
// Bit-serial-weight MAC: per-lane selected activations, shifted by weight bit position, summed per beat
// and accumulated over a first..last frame. Result is registered two edges after acceptance; stalls hold everything.
module mac_unit_bitlet_stream #(
  parameter int DATA_WIDTH   = 8,
  parameter int VEC_LENGTH   = 16,
  parameter int SEL_WIDTH    = $clog2(VEC_LENGTH),
  parameter int ACC_WIDTH    = 2*DATA_WIDTH+8,
  parameter int RESULT_WIDTH = 2*DATA_WIDTH,
  parameter bit SATURATE     = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   in_first,
  input  logic                                   in_last,
  input  logic                                   signed_mode,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  act_in,
  input  logic [DATA_WIDTH-1:0][SEL_WIDTH-1:0]   act_sel,
  input  logic [DATA_WIDTH-1:0]                  act_val,
  input  logic signed [ACC_WIDTH-1:0]            accum_prev,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [RESULT_WIDTH-1:0]         result
);

  localparam int PSUM_W = 2*DATA_WIDTH+1;
  localparam logic signed [ACC_WIDTH-1:0] RES_MAX =
    {{(ACC_WIDTH-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] RES_MIN = ~RES_MAX;

  logic signed [PSUM_W-1:0]       lane_op [DATA_WIDTH];
  logic signed [PSUM_W-1:0]       psum;
  logic                           s1_valid;
  logic                           s1_first;
  logic                           s1_last;
  logic signed [PSUM_W-1:0]       s1_psum;
  logic signed [ACC_WIDTH-1:0]    s1_accum_prev;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    acc_base;
  logic signed [ACC_WIDTH-1:0]    acc_next;
  logic signed [RESULT_WIDTH-1:0] res_next;
  logic                           stall;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Lane j carries weight bit j; out-of-range selects contribute nothing.
  always_comb begin
    for (int j = 0; j < DATA_WIDTH; j++) begin
      lane_op[j] = '0;
      if (act_val[j] && (32'(act_sel[j]) < VEC_LENGTH))
        lane_op[j] = PSUM_W'($signed(act_in[act_sel[j]])) << j;
    end
  end

  always_comb begin
    psum = '0;
    for (int j = 0; j < DATA_WIDTH-1; j++)
      psum = psum + lane_op[j];
    if (signed_mode)
      psum = psum - lane_op[DATA_WIDTH-1];
    else
      psum = psum + lane_op[DATA_WIDTH-1];
  end

  assign acc_base = s1_first ? s1_accum_prev : acc;
  assign acc_next = acc_base + ACC_WIDTH'(s1_psum);

  always_comb begin
    res_next = acc_next[RESULT_WIDTH-1:0];
    if (SATURATE) begin
      if (acc_next > RES_MAX)
        res_next = RES_MAX[RESULT_WIDTH-1:0];
      else if (acc_next < RES_MIN)
        res_next = RES_MIN[RESULT_WIDTH-1:0];
    end
  end

  // When not stalled, any pending result is being consumed this edge,
  // so out_valid simply follows whether a frame completes now.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid      <= 1'b0;
      s1_first      <= 1'b0;
      s1_last       <= 1'b0;
      s1_psum       <= '0;
      s1_accum_prev <= '0;
      acc           <= '0;
      result        <= '0;
      out_valid     <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_first      <= in_first;
        s1_last       <= in_last;
        s1_psum       <= psum;
        s1_accum_prev <= accum_prev;
      end
      if (s1_valid) begin
        acc <= acc_next;
        if (s1_last)
          result <= res_next;
      end
      out_valid <= s1_valid && s1_last;
    end
  end

endmodule

// File: tb/tb_mac_unit_bitlet_stream.sv
// Bench for mac_unit_bitlet_stream: directed literal cases plus randomized frames scored against
// a frame-level arithmetic model, for both saturating and truncating builds.
module tb_mac_unit_bitlet_stream;
  localparam int DW = 8;
  localparam int VL = 16;
  localparam int SW = 4;
  localparam int AW = 2*DW+8;
  localparam int RW = 2*DW;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_first, in_last, signed_mode, out_ready;
  logic [VL-1:0][DW-1:0] act_in;
  logic [DW-1:0][SW-1:0] act_sel;
  logic [DW-1:0]         act_val;
  logic signed [AW-1:0]  accum_prev;
  logic                  in_ready, out_valid, in_ready_t, out_valid_t;
  logic signed [RW-1:0]  result, result_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_unit_bitlet_stream #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .SATURATE(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .signed_mode(signed_mode),
    .act_in(act_in), .act_sel(act_sel), .act_val(act_val), .accum_prev(accum_prev),
    .out_valid(out_valid), .out_ready(out_ready), .result(result));

  mac_unit_bitlet_stream #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .SATURATE(1'b0)) dut_t (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_t),
    .in_first(in_first), .in_last(in_last), .signed_mode(signed_mode),
    .act_in(act_in), .act_sel(act_sel), .act_val(act_val), .accum_prev(accum_prev),
    .out_valid(out_valid_t), .out_ready(out_ready), .result(result_t));

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  longint m_acc;
  longint q_sat[$];
  longint q_trn[$];
  bit     prev_stall;
  longint prev_res, prev_res_t;

  function automatic longint beat_psum();
    longint s = 0;
    longint op;
    for (int j = 0; j < DW; j++) begin
      op = act_val[j] ? longint'($signed(act_in[act_sel[j]])) : 64'sd0;
      if (j == DW-1 && signed_mode) s = s - op * (longint'(1) << j);
      else                          s = s + op * (longint'(1) << j);
    end
    return s;
  endfunction

  function automatic longint wrap_bits(input longint v, input int w);
    longint m = v & ((longint'(1) << w) - 1);
    if (m >= (longint'(1) << (w-1))) m = m - (longint'(1) << w);
    return m;
  endfunction

  function automatic longint clamp_res(input longint v);
    longint hi = (longint'(1) << (RW-1)) - 1;
    if (v > hi) return hi;
    if (v < -hi-1) return -hi-1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      m_acc = 0;
      q_sat.delete();
      q_trn.delete();
      prev_stall = 0;
    end else begin
      check("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
      check("in_ready_trunc", longint'(in_ready_t), longint'(!(out_valid_t && !out_ready)));
      if (prev_stall) begin
        check("stall_hold_valid", longint'(out_valid), 1);
        check("stall_hold_result", longint'(result), prev_res);
        check("stall_hold_result_trunc", longint'(result_t), prev_res_t);
      end
      if (out_valid && out_ready) begin
        if (q_sat.size() == 0) check("unexpected_result", longint'(result), 64'sh7fffffff);
        else check("result_sat", longint'(result), q_sat.pop_front());
      end
      if (out_valid_t && out_ready) begin
        if (q_trn.size() == 0) check("unexpected_result_trunc", longint'(result_t), 64'sh7fffffff);
        else check("result_trunc", longint'(result_t), q_trn.pop_front());
      end
      if (in_valid && in_ready) begin
        if (in_first) m_acc = longint'(accum_prev);
        m_acc = wrap_bits(m_acc + beat_psum(), AW);
        if (in_last) begin
          q_sat.push_back(clamp_res(m_acc));
          q_trn.push_back(wrap_bits(m_acc, RW));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = longint'(result);
      prev_res_t = longint'(result_t);
    end
  end

  // ---------------- drivers ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 just after the acceptance edge.
  task automatic beat(input bit f, input bit l, input bit sm, input longint ap);
    int n = 0;
    in_valid = 1'b1; in_first = f; in_last = l; signed_mode = sm;
    accum_prev = AW'(ap);
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("result_timeout", 0, 1);
  endtask

  initial begin
    int cnt;
    longint seen;
    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    signed_mode = 1'b0; out_ready = 1'b1; accum_prev = '0;
    act_in = '0; act_sel = '0; act_val = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_result", longint'(result), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready", longint'(in_ready), 1);

    // act_in[3]=5 on every lane
    act_in = '0; act_in[3] = 8'd5; act_val = '1;
    for (int j = 0; j < DW; j++) act_sel[j] = 4'd3;
    sync(); beat(1, 1, 1, 0);
    @(negedge clk);
    check("lat_not_yet", longint'(out_valid), 0);
    @(negedge clk);
    check("lat_valid_signed", longint'(out_valid), 1);
    check("signed_all_lanes", longint'(result), -5);
    sync(); beat(1, 1, 0, 0);
    @(negedge clk); @(negedge clk);
    check("lat_valid_unsigned", longint'(out_valid), 1);
    check("unsigned_all_lanes", longint'(result), 1275);
    check("unsigned_all_lanes_trunc", longint'(result_t), 1275);

    // three back-to-back beats of psum 2, seed 10
    act_in = '0; act_in[0] = 8'd2; act_sel = '0; act_val = 8'b0000_0001;
    sync(); beat(1, 0, 1, 10); beat(0, 0, 1, 0); beat(0, 1, 1, 0);
    cnt = 0; seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) begin cnt++; seen = longint'(result); end
    end
    check("three_beat_count", cnt, 1);
    check("three_beat_result", seen, 16);

    // backpressure
    out_ready = 1'b0;
    sync(); beat(1, 1, 1, 100);
    @(negedge clk); wait_out();
    check("bp_first_result", longint'(result), 102);
    sync();
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; accum_prev = AW'(200);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_low", longint'(in_ready), 0);
      check("bp_result_held", longint'(result), 102);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); wait_out();
    check("bp_resume_result", longint'(result), 202);

    // saturation / truncation
    act_val = '0;
    sync(); beat(1, 1, 1, 40000);
    @(negedge clk); @(negedge clk);
    check("sat_pos", longint'(result), 32767);
    check("trunc_pos", longint'(result_t), -25536);
    sync(); beat(1, 1, 1, -40000);
    @(negedge clk); @(negedge clk);
    check("sat_neg", longint'(result), -32768);
    check("trunc_neg", longint'(result_t), 25536);

    // reset mid-frame discards it
    act_in = '0; act_in[0] = 8'd2; act_sel = '0; act_val = 8'b0000_0001;
    sync(); beat(1, 0, 1, 50);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", longint'(out_valid), 0);
    check("midreset_in_ready", longint'(in_ready), 1);
    act_in = '0; act_in[1] = 8'd7; act_sel[0] = 4'd1;
    sync(); beat(1, 0, 1, 0); beat(0, 1, 1, 0);
    @(negedge clk); wait_out();
    check("after_reset_result", longint'(result), 14);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      in_valid    = ($urandom_range(0, 3) != 0);
      in_first    = ($urandom_range(0, 3) == 0);
      in_last     = ($urandom_range(0, 3) == 0);
      signed_mode = 1'($urandom);
      out_ready   = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < VL; i++) act_in[i] = DW'($urandom);
      for (int j = 0; j < DW; j++) act_sel[j] = SW'($urandom);
      act_val     = DW'($urandom);
      accum_prev  = AW'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("drain_sat", longint'(q_sat.size()), 0);
    check("drain_trunc", longint'(q_trn.size()), 0);
    check("drain_out_valid", longint'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
